// File: rtl/mux_pipe.sv
// ---------------------------------------------------------------------------
// mux_pipe
//   Registered N:1 multiplexer with a valid/ready handshake on both sides.
//   The block picks one of NUM_IN channels and stores the result in an
//   output register. A one-entry skid register catches one extra word when
//   downstream stalls, so in_ready never depends on out_ready within a cycle.
//
// Parameters
//   WIDTH   data width in bits
//   NUM_IN  number of input channels (2..16)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel index, sampled together with in_data
//   in_valid   upstream offers in_data/sel
//   in_ready   block can accept this cycle (registered)
//   out_data   selected data, always the output register
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data
//   sel_err    sticky flag, set when an out-of-range index is accepted
// ---------------------------------------------------------------------------
module mux_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  outData_q;
  logic [WIDTH-1:0]  skidData_q;
  logic              inReady_q;
  logic              selErr_q;

  logic [WIDTH-1:0]  selValue;
  logic              selInRange;
  logic              inXfer;
  logic              outXfer;

  // When NUM_IN fills the whole select space every index is legal, so the
  // range check collapses to a constant and sel_err can never be set.
  generate
    if (NUM_IN == (1 << SEL_W)) begin : gFullRange
      assign selInRange = 1'b1;
    end else begin : gPartialRange
      assign selInRange = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
    end
  endgenerate

  // Pick channel sel out of the packed input bus; an index with no
  // matching channel leaves the default of all zeros.
  always_comb begin
    selValue = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        selValue = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign inXfer    = in_valid & inReady_q;
  assign outXfer   = out_valid & out_ready;

  assign in_ready  = inReady_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = outData_q;
  assign sel_err   = selErr_q;

  // Occupancy FSM. The output register is always the head of the queue and
  // the skid register only ever holds the second word. in_ready is updated
  // together with the state so it is a pure register output and stays low
  // exactly while both entries are full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b1;
      selErr_q   <= 1'b0;
    end else begin
      if (inXfer && !selInRange) begin
        selErr_q <= 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (inXfer) begin
            outData_q <= selValue;
            state_q   <= ONE;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            outData_q <= selValue;
          end else if (inXfer) begin
            skidData_q <= selValue;
            inReady_q  <= 1'b0;
            state_q    <= TWO;
          end else if (outXfer) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (outXfer) begin
            outData_q <= skidData_q;
            inReady_q <= 1'b1;
            state_q   <= ONE;
          end
        end
        default: begin
          state_q   <= EMPTY;
          inReady_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
